ctrl_mem: RTL
=============

Name: ctrl_mem

Overview:
Initiator-side controller for the word-wide data RAM: drives its write strobe (opM), read strobe (opR), word index (pos) and write data (valor), and captures its read data (salida). Sits between the CPU memory stage and the RAM. Accepts byte, half-word and word loads and stores over a valid/ready handshake. Sub-word stores are performed as read-modify-write on the RAM.

Parameters:
DEPTH, 10, number of 32-bit words in the RAM; valid word indices are 0..DEPTH-1.
AW, 32, byte-address width of the CPU request.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, synchronous, active-high.
req_valid  in  1  CPU request present.
req_ready  out  1  controller can accept a request; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  AW  byte address.
req_wdata  in  32  store data, right-aligned.
resp_valid  out  1  response available.
resp_ready  in  1  CPU takes the response.
resp_rdata  out  32  load result, extended; 0 for stores and errors.
resp_err  out  1  misaligned, out-of-range or illegal size.
opM  out  1  RAM write strobe.
opR  out  1  RAM read strobe.
pos  out  32  RAM word index = req_addr >> 2.
valor  out  32  RAM write data.
salida  in  32  RAM read data; combinational from pos while opR is high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - opM = 0, opR = 0, pos = 0, valor = 0.
  - Any in-flight access is abandoned; no RAM write is issued after reset.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready = 1. On req_valid, latch we/size/unsigned/addr/wdata, then:
  - Error if size == 11, addr misaligned (half: addr[0] != 0; word: addr[1:0] != 0), or word index >= DEPTH. Go to RESP with resp_err = 1; no RAM strobe is ever asserted.
  - Load, or store with size != word: go to RD.
  - Word store: go to WR.
- RD (1 cycle): opR = 1, pos = word index. salida is captured at the end of the cycle.
  - Load: extract the lane using little-endian order (byte lane = addr[1:0], half lane = addr[1]), extend, go to RESP.
  - Sub-word store: merge req_wdata into the captured word at that lane, go to WR.
- WR (1 cycle): opM = 1, pos = word index, valor = merged word or full word. Go to RESP.
- RESP: resp_valid = 1, held stable until resp_ready = 1; then return to IDLE.
- Strobes: opM and opR are never high together and are 0 outside RD/WR. pos and valor hold their last value when idle.
- Latency from accept to resp_valid: word load 2 cycles; word store 2; sub-word store 3; error 1.
- Back-to-back: the next request is accepted in the cycle after the response handshake. No overlap between requests.

Optional Feature:
CTRL_MEM_STATS_EN. When defined, adds three outputs, each 16 bits and saturating at 0xFFFF:
- cnt_ld: incremented on each completed successful load.
- cnt_st: incremented on each completed successful store.
- cnt_err: incremented on each error response.
All three counts increment on the RESP handshake and are cleared by rst. When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
Shared package ctrl_mem_pkg holds:
- size encodings SZ_B, SZ_H, SZ_W;
- state encodings ST_IDLE, ST_RD, ST_WR, ST_RESP.
One natural sub-module, ctrl_mem_lane: a purely combinational lane extract/extend (loads) and lane merge (stores), taking addr[1:0], size and unsigned.

Test Plan:
1. RAM word 3 = 0x8899AABB; load byte, signed, addr 0x0D -> resp_rdata 0xFFFFFFAA, resp_err 0; opR high for exactly 1 cycle with pos = 3; resp_valid 2 cycles after accept.
2. Same word; load half, unsigned, addr 0x0E -> 0x00008899.
3. RAM word 2 = 0x11223344; store byte 0xEE at addr 0x09 -> one RD cycle then one WR cycle with valor 0x1122EE44; later word load of addr 0x08 returns 0x1122EE44.
4. Store word at addr 0x06 (misaligned) and load word at addr 0x28 (index 10 >= DEPTH) -> each gives resp_err 1 and resp_rdata 0; opM and opR stay 0 throughout.
5. Hold resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata held stable, req_ready 0. Assert rst during WR -> next cycle all outputs at reset values and the RAM contents are unchanged.
6. With CTRL_MEM_STATS_EN: 2 loads, 1 store, 1 error -> cnt_ld 2, cnt_st 1, cnt_err 1; rst clears all three.

Source files
------------

// File: rtl/ctrl_mem_pkg.sv
// Shared encodings for the data-RAM controller: access sizes and FSM states.
package ctrl_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ctrl_mem_lane.sv
// Combinational little-endian lane logic: load extract/extend and sub-word store merge.
module ctrl_mem_lane
    import ctrl_mem_pkg::*;
(
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        uns,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);

    logic [31:0] shifted;

    assign shifted = rword >> {off, 3'b000};

    always_comb begin
        ldata = rword;
        case (size)
            SZ_B:    ldata = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    ldata = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ldata = rword;
        endcase
    end

    // Each byte lane picks either the new store byte or keeps the RAM byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       be;
            logic [7:0] wb;

            always_comb begin
                be = 1'b1;
                wb = wdata[8*gi +: 8];
                case (size)
                    SZ_B: begin
                        be = (off == LANE);
                        wb = wdata[7:0];
                    end
                    SZ_H: begin
                        be = (off[1] == LANE[1]);
                        wb = wdata[8*(gi%2) +: 8];
                    end
                    default: begin
                        be = 1'b1;
                        wb = wdata[8*gi +: 8];
                    end
                endcase
            end

            assign mdata[8*gi +: 8] = be ? wb : rword[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/ctrl_mem.sv
// CPU-side data RAM controller: sized loads/stores, sub-word stores via read-modify-write.
// Optional access counters are built when CTRL_MEM_STATS_EN is defined.
module ctrl_mem
    import ctrl_mem_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          opM,
    output logic          opR,
    output logic [31:0]   pos,
    output logic [31:0]   valor,
    input  logic [31:0]   salida
`ifdef CTRL_MEM_STATS_EN
    ,
    output logic [15:0]   cnt_ld,
    output logic [15:0]   cnt_st,
    output logic [15:0]   cnt_err
`endif
);

    state_t      state_reg, state_next;
    logic        we_reg;
    size_t       size_reg;
    logic        uns_reg;
    logic [1:0]  off_reg;
    logic [31:0] wdata_reg;
    logic [31:0] pos_reg;
    logic [31:0] valor_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        req_misalign;
    logic        req_range;
    logic        req_err;
    logic [31:0] req_idx;
    logic [31:0] ldata;
    logic [31:0] mdata;

    assign req_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                          ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign req_range    = (req_addr >> 2) >= AW'(DEPTH);
    assign req_err      = (req_size == SZ_X) || req_misalign || req_range;
    assign req_idx      = 32'(req_addr >> 2);

    ctrl_mem_lane u_lane (
        .off   (off_reg),
        .size  (size_reg),
        .uns   (uns_reg),
        .rword (salida),
        .wdata (wdata_reg),
        .ldata (ldata),
        .mdata (mdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (!req_we || (req_size != SZ_W))
                        state_next = ST_RD;
                    else
                        state_next = ST_WR;
                end
            end
            ST_RD:   state_next = we_reg ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            we_reg    <= 1'b0;
            size_reg  <= SZ_B;
            uns_reg   <= 1'b0;
            off_reg   <= 2'b00;
            wdata_reg <= 32'd0;
            pos_reg   <= 32'd0;
            valor_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        size_reg  <= size_t'(req_size);
                        uns_reg   <= req_unsigned;
                        off_reg   <= req_addr[1:0];
                        wdata_reg <= req_wdata;
                        err_reg   <= req_err;
                        rdata_reg <= 32'd0;
                        // Rejected requests leave the RAM-facing bus untouched.
                        if (!req_err)
                            pos_reg <= req_idx;
                        if (!req_err && req_we && (req_size == SZ_W))
                            valor_reg <= req_wdata;
                    end
                end
                ST_RD: begin
                    if (we_reg)
                        valor_reg <= mdata;
                    else
                        rdata_reg <= ldata;
                end
                default: ;
            endcase
        end
    end

    // Strobes are masked by rst so an access interrupted by reset never reaches the RAM.
    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP);
    assign opR        = (state_reg == ST_RD) && !rst;
    assign opM        = (state_reg == ST_WR) && !rst;
    assign pos        = pos_reg;
    assign valor      = valor_reg;
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

`ifdef CTRL_MEM_STATS_EN
    logic [15:0] cnt_ld_reg, cnt_st_reg, cnt_err_reg;
    logic        resp_fire;

    assign resp_fire = (state_reg == ST_RESP) && resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ld_reg  <= 16'd0;
            cnt_st_reg  <= 16'd0;
            cnt_err_reg <= 16'd0;
        end else if (resp_fire) begin
            if (err_reg) begin
                if (cnt_err_reg != 16'hFFFF) cnt_err_reg <= cnt_err_reg + 16'd1;
            end else if (we_reg) begin
                if (cnt_st_reg != 16'hFFFF) cnt_st_reg <= cnt_st_reg + 16'd1;
            end else begin
                if (cnt_ld_reg != 16'hFFFF) cnt_ld_reg <= cnt_ld_reg + 16'd1;
            end
        end
    end

    assign cnt_ld  = cnt_ld_reg;
    assign cnt_st  = cnt_st_reg;
    assign cnt_err = cnt_err_reg;
`endif

endmodule
